multi_key_debouncer: RTL and testbench
======================================

# multi_key_debouncer

Parametrised N-channel key debouncer. It replaces single-key, divided-clock debouncing with a fully synchronous design: one system clock, one shared clock-enable tick, and per-channel sampling, debounce, edge-pulse and long-press/auto-repeat logic. It sits between raw board key pins and the keyscan and consumer logic. It produces a clean level per key plus single-cycle event pulses in the `clk` domain.

## Interface
- `N_KEYS`, 4: number of independent key channels (≥1).
- `TICK_DIV`, 50000: `clk` cycles per sample tick (≥2); the default gives 1 ms at 50 MHz.
- `DEBOUNCE_TICKS`, 20: consecutive disagreeing ticks required to accept a level change (≥1).
- `LONG_TICKS`, 1000: ticks of continuous accepted press before `long_pulse`; 0 disables long press and repeat.
- `REPEAT_TICKS`, 200: tick period of `repeat_pulse` after a long press; 0 disables repeat.
- `ACTIVE_LOW`, 1: 1 means a raw key reads 0 when pressed; 0 means it reads 1 when pressed.

Ports:
- `clk` in 1: system clock; the only clock in the block.
- `rst` in 1: reset, synchronous, active-high.
- `key` in N_KEYS: raw asynchronous key inputs.
- `key_state` out N_KEYS: debounced level, 1 = pressed.
- `press_pulse` out N_KEYS: one-`clk` pulse when a press is accepted.
- `release_pulse` out N_KEYS: one-`clk` pulse when a release is accepted.
- `long_pulse` out N_KEYS: one-`clk` pulse when the long-press threshold is reached.
- `repeat_pulse` out N_KEYS: one-`clk` pulse at each auto-repeat interval.
- `tick` out 1: the internal sample enable, exported for sharing and test.

## Operation
Reset, when `rst` is 1 at a `clk` edge:
- All outputs go to 0 and all counters go to 0.
- The synchroniser flops load the inactive level (1 if `ACTIVE_LOW`, else 0).
- Reset takes priority over every other event, including mid-debounce and mid-hold.

Tick generator:
- `div_cnt` runs 0..`TICK_DIV`-1 and then wraps to 0.
- `tick` is 1 for exactly the one cycle in which `div_cnt` == `TICK_DIV`-1.
- The first `tick` after reset occurs `TICK_DIV` cycles after reset is released.

Per-channel input path:
- Each raw key passes through a 2-flop synchroniser.
- The synchronised value is then normalised to `pressed` (1 = pressed) according to `ACTIVE_LOW`.

Per-channel FSM states:
- **IDLE**: `key_state`=0.
- **PRESSED**: `key_state`=1, long press not yet reached.
- **HELD**: `key_state`=1, long press reached.

Debounce rule (evaluated only on `tick` cycles):
- If `pressed` != `key_state`, the debounce counter increments; otherwise it clears to 0.
- When the counter is at `DEBOUNCE_TICKS`-1 and `pressed` still disagrees on a tick:
  - the channel toggles `key_state`;
  - the debounce counter clears;
  - the hold and repeat counters clear.
- IDLE→PRESSED asserts `press_pulse`. PRESSED/HELD→IDLE asserts `release_pulse`.

Long press:
- In PRESSED, the hold counter increments on each tick while `pressed`=1.
- When the hold count reaches `LONG_TICKS`, the channel asserts `long_pulse`, moves to HELD, and clears the repeat counter.
- In HELD with `REPEAT_TICKS`>0, the repeat counter increments on each tick. When it reaches `REPEAT_TICKS`, the channel asserts `repeat_pulse` and clears the repeat counter.

Counter widths:
- Each counter uses `$clog2` of (its maximum value + 1).
- No counter may wrap. The hold counter stops once the channel is in HELD.

Channels are fully independent. Simultaneous events on different channels each produce their own pulse in the same cycle.

A bounce during the release debounce window does not affect the hold or repeat counters. Those counters keep advancing while `key_state`=1.

## Timing
- `key` to synchronised `pressed`: 2 `clk` cycles.
- Accepted change: on the `DEBOUNCE_TICKS`-th consecutive disagreeing tick. Worst case is 2 + `DEBOUNCE_TICKS`·`TICK_DIV` cycles after the raw edge.
- `key_state` and all pulses are registered.
- Each pulse is 1 in the cycle after the deciding `tick` cycle and lasts exactly 1 cycle.
- `press_pulse`/`release_pulse` coincide with the first cycle of the new `key_state` value.
- `long_pulse` and the first `repeat_pulse` can never coincide, because a repeat requires at least one further tick.

## Test plan
Bench parameters: `N_KEYS`=2, `TICK_DIV`=4, `DEBOUNCE_TICKS`=3, `LONG_TICKS`=8, `REPEAT_TICKS`=2, `ACTIVE_LOW`=1.

1. **Reset:** hold `rst`=1 for 3 cycles with `key`=2'b00 (pressed).
   - Required: all outputs 0 throughout.
   - After release, `tick` first goes high on cycle 4.
2. **Clean press/release:** drive `key[0]` to 0 and hold it.
   - Required: `key_state[0]` rises and `press_pulse[0]`=1 for one cycle after the 3rd tick that sees the synchronised low.
   - Then drive `key[0]` to 1 and hold it. Required: symmetric `release_pulse[0]` and `key_state[0]` falls.
   - `key[1]` stays 1 and its outputs stay 0.
3. **Bounce rejection:** toggle `key[0]` low for 2 ticks, high for 1 tick, and repeat this 5 times.
   - Required: `key_state[0]` stays 0 with no pulses.
   - Follow with a steady low; the press is accepted exactly 3 ticks later.
4. **Long press and repeat:** hold `key[1]` low for 20 ticks after acceptance.
   - Required: `long_pulse[1]` once, 8 ticks after `press_pulse[1]`.
   - Then `repeat_pulse[1]` every 2 ticks: 6 repeats within the 20 ticks.
   - On release, repeats stop and `release_pulse[1]` fires.
5. **Simultaneous channels:** press both keys on the same cycle.
   - Required: `press_pulse`=2'b11 in a single cycle.
   - Release `key[0]` only; required: `release_pulse`=2'b01, and `key[1]` hold timing is unaffected.
6. **Reset mid-hold:** assert `rst` while `key_state[1]`=1 and in HELD, with the key still pressed.
   - Required: the next cycle shows outputs 0 and no `release_pulse`.
   - After reset is released, the press is re-accepted after 3 ticks with a fresh `press_pulse[1]`.

Source files
------------

// File: rtl/multi_key_debouncer.sv
// N-channel key debouncer: one shared sample tick, 2-flop synchronisers,
// tick-based debounce, and press/release/long-press/auto-repeat pulses per key.
module multi_key_debouncer #(
  parameter int N_KEYS         = 4,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              tick
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int DEB_W  = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int HOLD_W = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;
  localparam int REP_W  = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
  localparam logic INACTIVE = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] toggle;

  state_t            state_q   [N_KEYS];
  state_t            state_d   [N_KEYS];
  logic [DEB_W-1:0]  deb_cnt_q [N_KEYS];
  logic [DEB_W-1:0]  deb_cnt_d [N_KEYS];
  logic [HOLD_W-1:0] hold_cnt_q[N_KEYS];
  logic [HOLD_W-1:0] hold_cnt_d[N_KEYS];
  logic [REP_W-1:0]  rep_cnt_q [N_KEYS];
  logic [REP_W-1:0]  rep_cnt_d [N_KEYS];

  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] long_q, long_d;
  logic [N_KEYS-1:0] repeat_q, repeat_d;

  assign tick          = (div_cnt_q == DIV_W'(TICK_DIV - 1));
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    sync1_d   = key;
    sync2_d   = sync1_q;
    pressed   = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    for (int i = 0; i < N_KEYS; i++) begin
      key_state[i] = (state_q[i] != IDLE);
    end
  end

  // Per-channel next state; an accepted level change overrides hold/repeat work on that tick.
  always_comb begin
    toggle    = '0;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    repeat_d  = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i]    = state_q[i];
      deb_cnt_d[i]  = deb_cnt_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      rep_cnt_d[i]  = rep_cnt_q[i];
      if (tick) begin
        if (pressed[i] != key_state[i]) begin
          if (deb_cnt_q[i] == DEB_W'(DEBOUNCE_TICKS - 1)) begin
            toggle[i]     = 1'b1;
            deb_cnt_d[i]  = '0;
            hold_cnt_d[i] = '0;
            rep_cnt_d[i]  = '0;
            if (state_q[i] == IDLE) begin
              state_d[i] = PRESSED;
              press_d[i] = 1'b1;
            end else begin
              state_d[i]   = IDLE;
              release_d[i] = 1'b1;
            end
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt_d[i] = '0;
        end

        // Hold and repeat advance on every tick while the accepted level is pressed.
        if (!toggle[i]) begin
          case (state_q[i])
            PRESSED: begin
              if (LONG_TICKS > 0) begin
                hold_cnt_d[i] = hold_cnt_q[i] + HOLD_W'(1);
                if (hold_cnt_q[i] == HOLD_W'(LONG_TICKS - 1)) begin
                  long_d[i]    = 1'b1;
                  state_d[i]   = HELD;
                  rep_cnt_d[i] = '0;
                end
              end
            end
            HELD: begin
              if (REPEAT_TICKS > 0) begin
                if (rep_cnt_q[i] == REP_W'(REPEAT_TICKS - 1)) begin
                  repeat_d[i]  = 1'b1;
                  rep_cnt_d[i] = '0;
                end else begin
                  rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sync1_q   <= {N_KEYS{INACTIVE}};
      sync2_q   <= {N_KEYS{INACTIVE}};
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i]    <= IDLE;
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
        rep_cnt_q[i]  <= '0;
      end
    end else begin
      div_cnt_q <= div_cnt_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i]    <= state_d[i];
        deb_cnt_q[i]  <= deb_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        rep_cnt_q[i]  <= rep_cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Bench for multi_key_debouncer: reset/tick table plus scoreboarded pulse events
// whose expected cycles are derived from tick arithmetic.
module tb_multi_key_debouncer;

  localparam int TD  = 4;
  localparam int DEB = 3;
  localparam int LT  = 8;
  localparam int RT  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key = 2'b00;
  logic [1:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic       tick;
  logic [7:0] pulses;

  multi_key_debouncer #(
    .N_KEYS(2), .TICK_DIV(TD), .DEBOUNCE_TICKS(DEB),
    .LONG_TICKS(LT), .REPEAT_TICKS(RT), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .key(key),
    .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .tick(tick)
  );

  always #5 clk = ~clk;

  assign pulses = {press_pulse, release_pulse, long_pulse, repeat_pulse};

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Cycle index since the last reset edge; pulses land on multiples of TD.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [7:0] ev;
  } ev_t;
  ev_t sb_q[$];

  typedef struct {
    logic       r;
    logic [1:0] k;
    logic       t;
    logic [1:0] st;
    logic [7:0] ev;
  } vec_t;
  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic void add_event(input int c, input logic [7:0] ev);
    ev_t e;
    e.cyc = c;
    e.ev  = ev;
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].cyc == c) begin
        e.ev    = sb_q[i].ev | ev;
        sb_q[i] = e;
        return;
      end
      if (sb_q[i].cyc > c) begin
        sb_q.insert(i, e);
        return;
      end
    end
    sb_q.push_back(e);
  endfunction

  // Sample index of the pulse that accepts a level change driven at sample s.
  function automatic int acc(input int s);
    int t;
    t = s + 2;
    while ((t % TD) != TD - 1) t++;
    return t + TD * (DEB - 1) + 1;
  endfunction

  function automatic void plan(input int ch, input int s_press, input int s_release);
    int p, r;
    p = acc(s_press);
    r = acc(s_release);
    add_event(p, 8'h01 << (6 + ch));
    if (p + TD * LT < r) begin
      add_event(p + TD * LT, 8'h01 << (2 + ch));
      for (int k = p + TD * (LT + RT); k < r; k += TD * RT)
        add_event(k, 8'h01 << ch);
    end
    add_event(r, 8'h01 << (4 + ch));
  endfunction

  always @(posedge clk) begin
    #1;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL missed_event: expected %b at cycle %0d, got none", sb_q[0].ev, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      checkOutput($sformatf("pulses@%0d", cyc), pulses, sb_q[0].ev);
      void'(sb_q.pop_front());
    end else if (pulses !== 8'h00) begin
      checkOutput($sformatf("unexpected_pulse@%0d", cyc), pulses, 8'h00);
    end
  end

  task automatic applyStimulus(input logic r, input logic [1:0] k);
    rst = r;
    key = k;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc != target && n < 1000) begin
      step();
      n++;
    end
    if (cyc != target) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_timeout: got cycle %0d expected %0d", cyc, target);
    end
  endtask

  task automatic align();
    wait_cyc((cyc / TD + 1) * TD);
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    checkOutput(name, {6'b0, key_state}, {6'b0, exp});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, p, b;

    vecs[0] = '{1'b1, 2'b00, 1'b0, 2'b00, 8'h00};
    vecs[1] = '{1'b1, 2'b00, 1'b0, 2'b00, 8'h00};
    vecs[2] = '{1'b1, 2'b00, 1'b0, 2'b00, 8'h00};
    vecs[3] = '{1'b0, 2'b11, 1'b0, 2'b00, 8'h00};
    vecs[4] = '{1'b0, 2'b11, 1'b0, 2'b00, 8'h00};
    vecs[5] = '{1'b0, 2'b11, 1'b1, 2'b00, 8'h00};
    vecs[6] = '{1'b0, 2'b11, 1'b0, 2'b00, 8'h00};
    vecs[7] = '{1'b0, 2'b11, 1'b0, 2'b00, 8'h00};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].r, vecs[i].k);
      step();
      checkOutput($sformatf("vec%0d_tick", i), {7'b0, tick}, {7'b0, vecs[i].t});
      checkOutput($sformatf("vec%0d_state", i), {6'b0, key_state}, {6'b0, vecs[i].st});
      checkOutput($sformatf("vec%0d_pulses", i), pulses, vecs[i].ev);
    end

    // Clean press and release on channel 0.
    s = cyc;
    p = acc(s);
    applyStimulus(1'b0, 2'b10);
    plan(0, s, p + 4);
    wait_cyc(p - 1);
    check_state("press0_before", 2'b00);
    step();
    check_state("press0_after", 2'b01);
    wait_cyc(p + 4);
    applyStimulus(1'b0, 2'b11);
    wait_cyc(acc(p + 4) - 1);
    check_state("release0_before", 2'b01);
    step();
    check_state("release0_after", 2'b00);

    // Bounce: low for two ticks, high for one, five times.
    align();
    for (int r = 0; r < 5; r++) begin
      b = cyc;
      applyStimulus(1'b0, 2'b10);
      wait_cyc(b + 8);
      applyStimulus(1'b0, 2'b11);
      wait_cyc(b + 11);
      check_state($sformatf("bounce%0d", r), 2'b00);
      wait_cyc(b + 12);
    end
    s = cyc;
    p = acc(s);
    applyStimulus(1'b0, 2'b10);
    plan(0, s, p + 4);
    wait_cyc(p - 1);
    check_state("bounce_settle_before", 2'b00);
    step();
    check_state("bounce_settle_after", 2'b01);
    wait_cyc(p + 4);
    applyStimulus(1'b0, 2'b11);
    wait_cyc(acc(p + 4) + 1);

    // Long press and auto-repeat on channel 1.
    align();
    s = cyc;
    p = acc(s);
    applyStimulus(1'b0, 2'b01);
    plan(1, s, p + 80);
    wait_cyc(p + 80);
    check_state("hold1_mid", 2'b10);
    applyStimulus(1'b0, 2'b11);
    wait_cyc(acc(p + 80) - 1);
    check_state("hold1_release_before", 2'b10);
    step();
    check_state("hold1_release_after", 2'b00);

    // Both channels pressed together; channel 0 released early.
    align();
    s = cyc;
    p = acc(s);
    applyStimulus(1'b0, 2'b00);
    plan(0, s, p + 8);
    plan(1, s, p + 60);
    wait_cyc(p);
    check_state("both_pressed", 2'b11);
    wait_cyc(p + 8);
    applyStimulus(1'b0, 2'b01);
    wait_cyc(p + 21);
    check_state("ch0_released", 2'b10);
    wait_cyc(p + 60);
    applyStimulus(1'b0, 2'b11);
    wait_cyc(acc(p + 60));
    check_state("both_released", 2'b00);

    // Reset while channel 1 is in the long-press state with the key still down.
    align();
    s = cyc;
    p = acc(s);
    applyStimulus(1'b0, 2'b01);
    add_event(p, 8'h80);
    add_event(p + TD * LT, 8'h08);
    wait_cyc(p + 36);
    check_state("held_before_reset", 2'b10);
    applyStimulus(1'b1, 2'b01);
    sb_q.delete();
    step();
    check_state("reset_state", 2'b00);
    checkOutput("reset_pulses", pulses, 8'h00);
    checkOutput("reset_tick", {7'b0, tick}, 8'h00);
    applyStimulus(1'b0, 2'b01);
    plan(1, 0, 16);
    wait_cyc(11);
    check_state("repress_before", 2'b00);
    step();
    check_state("repress_after", 2'b10);
    wait_cyc(16);
    applyStimulus(1'b0, 2'b11);
    wait_cyc(acc(16) + 4);
    check_state("final_state", 2'b00);
    checkOutput("scoreboard_drained", 8'(sb_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
